inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch path: owns the PC, issues one read per instruction
//  to the instruction ROM, and captures the returned word into Inst_Code/Inst_PC.
//  Presents each word to decode with a valid/ready handshake and applies branch/jump
//  redirects. Sits between the instruction memory and the decode/translate stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word-aligned
//  MEM_LAT   1              cycles from Mem_Req to valid Mem_Rdata; legal range 1..7
// PORTS
//  Clk          in   1   clock, rising edge
//  Rst          in   1   synchronous active-high reset
//  Mem_Req      out  1   one-cycle read strobe to instruction ROM
//  Mem_Addr     out  32  byte address of read; equals PC while Mem_Req=1
//  Mem_Rdata    in   32  ROM data, valid MEM_LAT cycles after the Mem_Req cycle
//  Redir_Valid  in   1   branch/jump taken this cycle
//  Redir_PC     in   32  redirect target; bits [1:0] ignored (forced 0)
//  Inst_Valid   out  1   Inst_Code/Inst_PC hold a live instruction
//  Inst_Ready   in   1   decode accepts the instruction this cycle
//  Inst_Code    out  32  fetched instruction word
//  Inst_PC      out  32  address of Inst_Code
//  PC           out  32  next fetch address
// BEHAVIOUR
//  Reset (Rst=1 at an edge, overrides everything, including mid-fetch): PC=RESET_PC,
//   state IDLE, Mem_Req=0, Mem_Addr=RESET_PC, Inst_Valid=0, Inst_Code=0, Inst_PC=0,
//   latency counter=0, squash flag=0.
//  FSM: IDLE -> REQ (unconditional, one cycle after reset release).
//   REQ: Mem_Req=1 for exactly this cycle, Mem_Addr=PC; counter<=MEM_LAT; -> WAIT.
//   WAIT: counter decrements each cycle. In the cycle where Mem_Rdata is valid
//    (MEM_LAT cycles after REQ), the capture edge happens: if squash=0, Inst_Code<=Mem_Rdata,
//    Inst_PC<=PC, PC<=PC+4, Inst_Valid<=1, -> HOLD. If squash=1, drop data,
//    clear squash, -> REQ.
//   HOLD: Inst_Valid=1 and Inst_Code/Inst_PC stable until Inst_Valid&Inst_Ready;
//    on handshake edge Inst_Valid<=0, -> REQ.
//  Timing: Mem_Req in cycle n -> Inst_Valid first high in cycle n+MEM_LAT+1.
//   Peak rate with Inst_Ready=1 is one instruction per MEM_LAT+2 cycles.
//   With reset released before cycle 0: IDLE in cycle 0, REQ in cycle 1.
//  Redirect (Redir_Valid=1, state != IDLE): PC<={Redir_PC[31:2],2'b00} at that edge.
//   Redirect has priority over PC+4.
//   -REQ: request already issued at old PC; set squash; the response is discarded.
//   -WAIT: set squash; the in-flight response is discarded. If this is the capture cycle,
//    nothing is captured -> REQ.
//   -HOLD: Inst_Valid<=0, -> REQ (held word flushed). If Inst_Ready=1 in the same cycle,
//    the handshake counts as completed (decode consumed it); the PC is still redirected.
//   -IDLE: Redir_Valid is ignored.
//  Arithmetic: PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000. No misalignment
//   possible.
//  Inst_Ready while Inst_Valid=0 is ignored. Mem_Rdata is sampled only on the capture edge.
// TESTING (ROM model with MEM_LAT delay, word i = 32'hA000_0000+i)
//  1 Reset release, Inst_Ready=1 -> Mem_Req in cycle 1 at 0x0; Inst_Valid in cycle 3,
//    Inst_Code=A0000000, Inst_PC=0; next fetch at 0x4; PC steps 0,4,8 each 3 cycles.
//  2 Inst_Ready=0 for 5 cycles in HOLD -> Inst_Valid and Inst_Code held; no Mem_Req;
//    PC=4; release -> Mem_Req at 0x4 next cycle.
//  3 Redir_Valid=1 with Redir_PC=0x43 during WAIT -> stale word never valid;
//    next Mem_Addr=0x40; Inst_PC=0x40, Inst_Code=A0000010.
//  4 Redir_Valid=1 with Redir_PC=0x100 during HOLD, Inst_Ready=0 -> Inst_Valid drops
//    next cycle; next fetch at 0x100. Repeat with Inst_Ready=1: same PC result.
//  5 RESET_PC=32'hFFFF_FFFC -> first Inst_PC=FFFFFFFC; next Mem_Addr=0x0.
//  6 Rst pulsed in WAIT and in HOLD -> all outputs at reset values next cycle;
//    fetch restarts at RESET_PC; MEM_LAT=3 variant gives Inst_Valid in cycle 5.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction ROM request/response, redirect input and
// the valid/ready instruction output towards decode.
interface inst_fetch_ctrl_if;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Rdata;
  logic        Redir_Valid;
  logic [31:0] Redir_PC;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Inst_Code;
  logic [31:0] Inst_PC;
  logic [31:0] PC;

  modport master (
    output Mem_Req, Mem_Addr, Inst_Valid, Inst_Code, Inst_PC, PC,
    input  Mem_Rdata, Redir_Valid, Redir_PC, Inst_Ready
  );

  modport slave (
    input  Mem_Req, Mem_Addr, Inst_Valid, Inst_Code, Inst_PC, PC,
    output Mem_Rdata, Redir_Valid, Redir_PC, Inst_Ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: one ROM read per instruction, captured word held
// for decode under valid/ready, with branch/jump redirects squashing in-flight reads.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic Clk,
  input  logic Rst,
  inst_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] code_q;
  logic [31:0] inst_pc_q;
  logic        valid_q;
  logic        req_q;
  logic        squash_q;
  logic [2:0]  cnt_q;

  logic [31:0] redir_pc_d;
  logic [31:0] pc_inc_d;
  logic        capture_d;

  assign redir_pc_d = bus.Redir_PC & 32'hFFFF_FFFC;
  assign pc_inc_d   = pc_q + 32'd4;
  assign capture_d  = (cnt_q == 3'd1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      code_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      squash_q  <= 1'b0;
      cnt_q     <= 3'd0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          cnt_q   <= LAT;
          state_q <= WAIT;
          // The read has already gone out at the old PC; its response must be dropped.
          if (bus.Redir_Valid) begin
            pc_q     <= redir_pc_d;
            squash_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (capture_d) begin
            if (squash_q || bus.Redir_Valid) begin
              squash_q <= 1'b0;
              state_q  <= REQ;
              req_q    <= 1'b1;
              if (bus.Redir_Valid) begin
                pc_q <= redir_pc_d;
              end
            end else begin
              code_q    <= bus.Mem_Rdata;
              inst_pc_q <= pc_q;
              pc_q      <= pc_inc_d;
              valid_q   <= 1'b1;
              state_q   <= HOLD;
            end
          end else if (bus.Redir_Valid) begin
            pc_q     <= redir_pc_d;
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect flushes the held word whether or not decode takes it this cycle.
          if (bus.Redir_Valid) begin
            pc_q    <= redir_pc_d;
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end else if (bus.Inst_Ready) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Mem_Req    = req_q;
  assign bus.Mem_Addr   = pc_q;
  assign bus.Inst_Valid = valid_q;
  assign bus.Inst_Code  = code_q;
  assign bus.Inst_PC    = inst_pc_q;
  assign bus.PC         = pc_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: three instances (default, wrap-around reset PC,
// three-cycle ROM latency), each with a ROM model and an in-order scoreboard.
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [2:0]       rst;
  logic [2:0]       rdy;
  logic [2:0]       rv;
  logic [2:0][31:0] rpc;

  logic [2:0]       mreq;
  logic [2:0]       ivalid;
  logic [2:0][31:0] maddr;
  logic [2:0][31:0] icode;
  logic [2:0][31:0] ipc;
  logic [2:0][31:0] pcv;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] code;
    int          vcyc;
  } exp_t;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int          LAT = (gi == 2) ? 3 : 1;
    localparam logic [31:0] RPC = (gi == 1) ? 32'hFFFF_FFFC : 32'h0000_0000;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.RESET_PC(RPC), .MEM_LAT(LAT)) u_dut (
      .Clk (clk),
      .Rst (rst[gi]),
      .bus (bus)
    );

    logic [31:0]    pipe_d [LAT];
    logic [LAT-1:0] pipe_v;

    always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) begin
        pipe_d[k] <= pipe_d[k-1];
        pipe_v[k] <= pipe_v[k-1];
      end
      pipe_d[0] <= rom(bus.Mem_Addr);
      pipe_v[0] <= bus.Mem_Req;
      if (rst[gi]) pipe_v <= '0;
    end

    assign bus.Mem_Rdata   = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEAD_BEEF;
    assign bus.Inst_Ready  = rdy[gi];
    assign bus.Redir_Valid = rv[gi];
    assign bus.Redir_PC    = rpc[gi];

    assign mreq[gi]   = bus.Mem_Req;
    assign maddr[gi]  = bus.Mem_Addr;
    assign ivalid[gi] = bus.Inst_Valid;
    assign icode[gi]  = bus.Inst_Code;
    assign ipc[gi]    = bus.Inst_PC;
    assign pcv[gi]    = bus.PC;

    exp_t        sb [$];
    int          cyc;
    logic [31:0] exp_fetch;
    logic        prev_valid;
    logic        first_req;

    initial begin
      exp_t e;
      cyc = 0; exp_fetch = RPC; prev_valid = 1'b0; first_req = 1'b1;
      forever begin
        @(negedge clk);
        if (rst[gi]) begin
          sb.delete();
          cyc = 0; exp_fetch = RPC; prev_valid = 1'b0; first_req = 1'b1;
        end else begin
          if (cyc == 0) begin
            chk($sformatf("d%0d_rst_req", gi),   32'(mreq[gi]), 32'h0);
            chk($sformatf("d%0d_rst_addr", gi),  maddr[gi], RPC);
            chk($sformatf("d%0d_rst_pc", gi),    pcv[gi], RPC);
            chk($sformatf("d%0d_rst_valid", gi), 32'(ivalid[gi]), 32'h0);
            chk($sformatf("d%0d_rst_code", gi),  icode[gi], 32'h0);
            chk($sformatf("d%0d_rst_ipc", gi),   ipc[gi], 32'h0);
          end
          if (mreq[gi]) begin
            chk($sformatf("d%0d_req_addr", gi), maddr[gi], exp_fetch);
            if (first_req) chk($sformatf("d%0d_req_cycle", gi), 32'(cyc), 32'd1);
            first_req = 1'b0;
            e.addr = exp_fetch;
            e.code = rom(exp_fetch);
            e.vcyc = cyc + LAT + 1;
            sb.push_back(e);
            exp_fetch = exp_fetch + 32'd4;
          end
          if (sb.size() == 0) begin
            chk($sformatf("d%0d_spurious_valid", gi), 32'(ivalid[gi]), 32'h0);
          end else if (ivalid[gi]) begin
            chk($sformatf("d%0d_code", gi), icode[gi], sb[0].code);
            chk($sformatf("d%0d_ipc", gi), ipc[gi], sb[0].addr);
            chk($sformatf("d%0d_pc_out", gi), pcv[gi], exp_fetch);
            chk($sformatf("d%0d_req_in_hold", gi), 32'(mreq[gi]), 32'h0);
            if (!prev_valid) chk($sformatf("d%0d_valid_cycle", gi), 32'(cyc), 32'(sb[0].vcyc));
            if (rdy[gi]) begin
              $display("d%0d cycle %0d: inst pc=%h code=%h", gi, cyc, ipc[gi], icode[gi]);
              void'(sb.pop_front());
            end
          end
          if (rv[gi]) begin
            sb.delete();
            exp_fetch = rpc[gi] & 32'hFFFF_FFFC;
          end
          prev_valid = ivalid[gi];
          cyc++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for Inst_Valid or Mem_Req of instance d; returns at that cycle's negedge.
  task automatic wait_sig(input int d, input bit want_valid, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = want_valid ? ivalid[d] : mreq[d];
    end
    chk(tag, 32'(seen), 32'h1);
  endtask

  initial begin
    rst = '1; rdy = '1; rv = '0; rpc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (12) next_cycle();

    // Held instruction with decode stalled, then release.
    rst[0] = 1'b1; rdy[0] = 1'b0;
    next_cycle();
    rst[0] = 1'b0;
    repeat (3) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(ivalid[0]), 32'h1);
      chk("t2_code", icode[0], 32'hA000_0000);
      chk("t2_pc", pcv[0], 32'h4);
      chk("t2_noreq", 32'(mreq[0]), 32'h0);
      next_cycle();
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_req", 32'(mreq[0]), 32'h1);
    chk("t2_addr", maddr[0], 32'h4);

    // Redirect in the capture cycle of WAIT.
    next_cycle();
    rv[0] = 1'b1; rpc[0] = 32'h43;
    next_cycle();
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t3_req", 32'(mreq[0]), 32'h1);
    chk("t3_addr", maddr[0], 32'h40);
    chk("t3_novalid", 32'(ivalid[0]), 32'h0);
    repeat (2) @(negedge clk);
    chk("t3_valid", 32'(ivalid[0]), 32'h1);
    chk("t3_code", icode[0], 32'hA000_0010);
    chk("t3_ipc", ipc[0], 32'h40);

    // Redirect in the REQ cycle.
    next_cycle();
    rv[0] = 1'b1; rpc[0] = 32'h200;
    next_cycle();
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t3r_drop", 32'(ivalid[0]), 32'h0);
    @(negedge clk);
    chk("t3r_req", 32'(mreq[0]), 32'h1);
    chk("t3r_addr", maddr[0], 32'h200);

    // Redirect in HOLD, decode stalled then accepting.
    next_cycle();
    rdy[0] = 1'b0;
    wait_sig(0, 1'b1, "t4_wait_valid");
    next_cycle();
    rv[0] = 1'b1; rpc[0] = 32'h100;
    next_cycle();
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t4_flush", 32'(ivalid[0]), 32'h0);
    chk("t4_req", 32'(mreq[0]), 32'h1);
    chk("t4_addr", maddr[0], 32'h100);
    wait_sig(0, 1'b1, "t4b_wait_valid");
    next_cycle();
    rdy[0] = 1'b1; rv[0] = 1'b1; rpc[0] = 32'h100;
    next_cycle();
    rv[0] = 1'b0;
    @(negedge clk);
    chk("t4b_flush", 32'(ivalid[0]), 32'h0);
    chk("t4b_req", 32'(mreq[0]), 32'h1);
    chk("t4b_addr", maddr[0], 32'h100);

    // Reset pulsed in WAIT, then in HOLD.
    wait_sig(0, 1'b0, "t6_wait_req");
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0; rdy[0] = 1'b0;
    wait_sig(0, 1'b1, "t6_wait_valid");
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0; rdy[0] = 1'b1;
    @(negedge clk);
    chk("t6_hold_valid", 32'(ivalid[0]), 32'h0);
    chk("t6_hold_code", icode[0], 32'h0);
    chk("t6_hold_ipc", ipc[0], 32'h0);
    chk("t6_hold_pc", pcv[0], 32'h0);
    next_cycle();

    // Reset PC at the top of the address space.
    rst[1] = 1'b0;
    wait_sig(1, 1'b1, "t5_wait_valid");
    chk("t5_ipc", ipc[1], 32'hFFFF_FFFC);
    chk("t5_code", icode[1], 32'hDFFF_FFFF);
    chk("t5_pc", pcv[1], 32'h0);
    wait_sig(1, 1'b0, "t5_wait_req");
    chk("t5_addr", maddr[1], 32'h0);
    next_cycle();

    // Three-cycle ROM latency.
    rst[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t6_lat3_valid_c%0d", c), 32'(ivalid[2]), (c == 5) ? 32'h1 : 32'h0);
    end
    wait_sig(2, 1'b0, "t6_lat3_wait_req");
    next_cycle();
    rv[2] = 1'b1; rpc[2] = 32'h80;
    next_cycle();
    rv[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_lat3_drop", 32'(ivalid[2]), 32'h0);
    chk("t6_lat3_req", 32'(mreq[2]), 32'h1);
    chk("t6_lat3_addr", maddr[2], 32'h80);
    wait_sig(2, 1'b0, "t6_lat3_wait_req2");
    next_cycle();
    rst[2] = 1'b1;
    next_cycle();
    rst[2] = 1'b0;
    repeat (12) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
